alu_unit: RTL and testbench

Execution unit at the consuming end of the reservation-station dispatch port. It accepts one ready RV32I integer instruction per cycle: operands, immediate, pc and ROB position. It computes the result and branch/jump resolution, then drives the result broadcast consumed by the reservation station, load-store buffer and ROB. Results are registered, so the broadcast bus never carries a combinational path from dispatch.

---
 rtl/alu_unit.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_alu_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
//
// Integer execution unit for RV32I, at the consuming end of the
// reservation-station dispatch port. Each accepted instruction produces exactly
// one registered result broadcast: writeback value, ROB tag, control-transfer
// flag and the resolved next pc.
//
// Build option:
//   ALU_PIPE2_EN  when defined, the unit uses two stages (latency 2):
//                 stage 1 registers the decoded operands, pc+imm, pc+4, the
//                 op class and the tag; stage 2 computes and registers the
//                 outputs. When undefined, there is one stage (latency 1).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rdy               global ready; low freezes every register
//   rollback          flush all in-flight work; drops a same-cycle dispatch
//   alu_en            dispatch valid (no backpressure, always accepted)
//   alu_opcode/funct3/funct7, alu_val1/val2/imm/pc, alu_rob_pos
//                     the dispatched instruction
//   result            broadcast valid, one cycle per instruction
//   result_rob_pos, result_val, result_jump, result_pc
//                     broadcast payload
//
// Handshake: alu_en is a valid-only strobe; the unit has no ready output and
// accepts every dispatch sampled with rdy=1 and rollback=0. result is a
// valid-only strobe; consumers must take the payload in the cycle it is high.
// -----------------------------------------------------------------------------
module alu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        alu_en,
  input  logic [6:0]  alu_opcode,
  input  logic [2:0]  alu_funct3,
  input  logic        alu_funct7,
  input  logic [31:0] alu_val1,
  input  logic [31:0] alu_val2,
  input  logic [31:0] alu_imm,
  input  logic [31:0] alu_pc,
  input  logic [3:0]  alu_rob_pos,
  output logic        result,
  output logic [3:0]  result_rob_pos,
  output logic [31:0] result_val,
  output logic        result_jump,
  output logic [31:0] result_pc
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_ALU    = 3'd1,
    CL_LUI    = 3'd2,
    CL_AUIPC  = 3'd3,
    CL_JAL    = 3'd4,
    CL_JALR   = 3'd5,
    CL_BRANCH = 3'd6
  } op_class_e;

  // Decoded instruction: everything execution needs, with the second operand
  // already selected between rs2 and the immediate.
  typedef struct packed {
    op_class_e   cls;
    logic [2:0]  funct3;
    logic        alt;      // SUB / SRA select, already qualified by opcode
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] pc_imm;
    logic [31:0] pc_4;
    logic [3:0]  rob_pos;
  } dec_t;

  typedef struct packed {
    logic [3:0]  rob_pos;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } res_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  function automatic dec_t decode(
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic        funct7,
    input logic [31:0] val1,
    input logic [31:0] val2,
    input logic [31:0] imm,
    input logic [31:0] pc,
    input logic [3:0]  rob_pos
  );
    dec_t d;
    d.cls     = CL_NONE;
    d.funct3  = funct3;
    d.alt     = 1'b0;
    d.op_a    = val1;
    d.op_b    = val2;
    d.pc_imm  = pc + imm;
    d.pc_4    = pc + 32'd4;
    d.rob_pos = rob_pos;
    case (opcode)
      OPC_OP: begin
        d.cls = CL_ALU;
        d.alt = funct7;
      end
      OPC_OP_IMM: begin
        d.cls  = CL_ALU;
        d.op_b = imm;
        // ADDI has no subtract form; instr[30] only matters for SRAI.
        d.alt  = funct7 && (funct3 == 3'b101);
      end
      OPC_LUI: begin
        d.cls  = CL_LUI;
        d.op_b = imm;
      end
      OPC_AUIPC: d.cls = CL_AUIPC;
      OPC_JAL:   d.cls = CL_JAL;
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          d.cls  = CL_JALR;
          d.op_b = imm;
        end
      end
      OPC_BRANCH: begin
        // 010 and 011 are not branch encodings; they fall through as CL_NONE.
        if (funct3 != 3'b010 && funct3 != 3'b011) d.cls = CL_BRANCH;
      end
      default: d.cls = CL_NONE;
    endcase
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Execute
  // ---------------------------------------------------------------------------
  function automatic res_t execute(input dec_t d);
    res_t        r;
    logic [31:0] alu_y;
    logic [31:0] sum;
    logic [4:0]  shamt;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        take;

    shamt = d.op_b[4:0];
    sum   = d.op_a + d.op_b;
    eq    = (d.op_a == d.op_b);
    lt    = ($signed(d.op_a) < $signed(d.op_b));
    ltu   = (d.op_a < d.op_b);

    case (d.funct3)
      3'b000:  alu_y = d.alt ? (d.op_a - d.op_b) : sum;
      3'b001:  alu_y = d.op_a << shamt;
      3'b010:  alu_y = {31'd0, lt};
      3'b011:  alu_y = {31'd0, ltu};
      3'b100:  alu_y = d.op_a ^ d.op_b;
      3'b101:  alu_y = d.alt ? 32'($signed(d.op_a) >>> shamt) : (d.op_a >> shamt);
      3'b110:  alu_y = d.op_a | d.op_b;
      default: alu_y = d.op_a & d.op_b;
    endcase

    case (d.funct3)
      3'b000:  take = eq;
      3'b001:  take = !eq;
      3'b100:  take = lt;
      3'b101:  take = !lt;
      3'b110:  take = ltu;
      3'b111:  take = !ltu;
      default: take = 1'b0;
    endcase

    // Unrecognised instructions keep these defaults so the ROB entry completes.
    r.rob_pos = d.rob_pos;
    r.val     = 32'd0;
    r.jump    = 1'b0;
    r.pc      = d.pc_4;

    case (d.cls)
      CL_ALU:   r.val = alu_y;
      CL_LUI:   r.val = d.op_b;
      CL_AUIPC: r.val = d.pc_imm;
      CL_JAL: begin
        r.val  = d.pc_4;
        r.jump = 1'b1;
        r.pc   = d.pc_imm;
      end
      CL_JALR: begin
        r.val  = d.pc_4;
        r.jump = 1'b1;
        r.pc   = {sum[31:1], 1'b0};
      end
      CL_BRANCH: begin
        if (take) begin
          r.jump = 1'b1;
          r.pc   = d.pc_imm;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  dec_t dec_w;
  dec_t exec_in;
  logic exec_valid;
  res_t exec_res;

  assign dec_w = decode(alu_opcode, alu_funct3, alu_funct7, alu_val1,
                        alu_val2, alu_imm, alu_pc, alu_rob_pos);

`ifdef ALU_PIPE2_EN
  dec_t s1_q;
  dec_t s1_d;
  logic s1_valid_q;
  logic s1_valid_d;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (rdy) begin
      s1_valid_d = alu_en;
      if (alu_en) s1_d = dec_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  assign exec_in    = s1_q;
  assign exec_valid = s1_valid_q;
`else
  assign exec_in    = dec_w;
  assign exec_valid = alu_en;
`endif

  assign exec_res = execute(exec_in);

  // ---------------------------------------------------------------------------
  // Output register: the broadcast bus is driven only from here.
  // ---------------------------------------------------------------------------
  logic result_q;
  logic result_d;
  res_t res_q;
  res_t res_d;

  always_comb begin
    result_d = result_q;
    res_d    = res_q;
    if (rdy) begin
      result_d = exec_valid;
      if (exec_valid) res_d = exec_res;
    end
  end

  // Rollback is checked ahead of rdy so a flush always lands.
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      result_q <= 1'b0;
      res_q    <= '0;
    end else begin
      result_q <= result_d;
      res_q    <= res_d;
    end
  end

  assign result         = result_q;
  assign result_rob_pos = res_q.rob_pos;
  assign result_val     = res_q.val;
  assign result_jump    = res_q.jump;
  assign result_pc      = res_q.pc;

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

`ifdef ALU_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int W = 69;  // {rob_pos, val, jump, pc}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic [31:0] alu_imm;
  logic [31:0] alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        result;
  logic [3:0]  result_rob_pos;
  logic [31:0] result_val;
  logic        result_jump;
  logic [31:0] result_pc;

  alu_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .alu_en         (alu_en),
    .alu_opcode     (alu_opcode),
    .alu_funct3     (alu_funct3),
    .alu_funct7     (alu_funct7),
    .alu_val1       (alu_val1),
    .alu_val2       (alu_val2),
    .alu_imm        (alu_imm),
    .alu_pc         (alu_pc),
    .alu_rob_pos    (alu_rob_pos),
    .result         (result),
    .result_rob_pos (result_rob_pos),
    .result_val     (result_val),
    .result_jump    (result_jump),
    .result_pc      (result_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_got;
  logic [W-1:0] sb_exp;
  logic         adv = 1'b0;

  // A broadcast is fresh only if the edge that produced it actually advanced.
  always @(posedge clk) adv <= rdy && !rst && !rollback;

  always @(negedge clk) begin
    if (adv && result === 1'b1) begin
      n_tests++;
      sb_got = {result_rob_pos, result_val, result_jump, result_pc};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_broadcast: got rob=%0d val=%h jump=%0b pc=%h, required no broadcast",
                 result_rob_pos, result_val, result_jump, result_pc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          n_fail++;
          $display("FAIL scoreboard: got rob=%0d val=%h jump=%0b pc=%h, required rob=%0d val=%h jump=%0b pc=%h",
                   sb_got[68:65], sb_got[64:33], sb_got[32], sb_got[31:0],
                   sb_exp[68:65], sb_exp[64:33], sb_exp[32], sb_exp[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                     input logic [31:0] v1, input logic [31:0] v2,
                     input logic [31:0] imm, input logic [31:0] pc,
                     input logic [3:0] rob);
    alu_en      = 1'b1;
    alu_opcode  = opc;
    alu_funct3  = f3;
    alu_funct7  = f7;
    alu_val1    = v1;
    alu_val2    = v2;
    alu_imm     = imm;
    alu_pc      = pc;
    alu_rob_pos = rob;
  endtask

  task automatic expect_res(input logic [3:0] rob, input logic [31:0] val,
                            input logic jump, input logic [31:0] pc);
    exp_q.push_back({rob, val, jump, pc});
  endtask

  task automatic dispatch(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [3:0] rob,
                          input logic [31:0] e_val, input logic e_jump,
                          input logic [31:0] e_pc);
    put(opc, f3, f7, v1, v2, imm, pc, rob);
    expect_res(rob, e_val, e_jump, e_pc);
    cycle();
  endtask

  task automatic drain();
    alu_en = 1'b0;
    repeat (LAT + 1) cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    put(7'b0110011, 3'($urandom_range(0, 7)), 1'b0, $urandom, $urandom, $urandom,
        $urandom, 4'($urandom_range(0, 15)));
    repeat (3) cycle();
    rst    = 1'b0;
    alu_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (result !== 1'b0 || result_pc !== 32'd0 || result_val !== 32'd0 ||
          result_jump !== 1'b0 || result_rob_pos !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got result=%b pc=%h val=%h jump=%b rob=%h, required all zero",
                 i, result, result_pc, result_val, result_jump, result_rob_pos);
      end
      cycle();
    end
  endtask

  task automatic test_latency_sub();
    dispatch(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'h80, 4'd3,
             32'hFFFF_FFFE, 1'b0, 32'h84);
    alu_en = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      n_tests++;
      if (result !== (k == LAT)) begin
        n_fail++;
        $display("FAIL latency[%0d]: got result=%b, required %b", k, result, (k == LAT));
      end
      cycle();
    end
  endtask

  task automatic test_shift_slt();
    dispatch(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h10, 4'd1,
             32'hF800_0000, 1'b0, 32'h14);
    dispatch(7'b0010011, 3'b101, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'h14, 4'd2,
             32'h0800_0000, 1'b0, 32'h18);
    // only the low five bits of rs2 shift
    dispatch(7'b0110011, 3'b001, 1'b0, 32'd1, 32'h23, 32'd0, 32'h18, 4'd3,
             32'd8, 1'b0, 32'h1C);
    dispatch(7'b0110011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1C, 4'd4,
             32'd1, 1'b0, 32'h20);
    dispatch(7'b0110011, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h20, 4'd5,
             32'd0, 1'b0, 32'h24);
    // ADDI ignores instr[30]
    dispatch(7'b0010011, 3'b000, 1'b1, 32'd10, 32'd0, 32'd3, 32'h24, 4'd6,
             32'd13, 1'b0, 32'h28);
    drain();
  endtask

  task automatic test_branch();
    dispatch(7'b1100011, 3'b100, 1'b0, -32'sd3, 32'd2, 32'h20, 32'h100, 4'd7,
             32'd0, 1'b1, 32'h120);
    dispatch(7'b1100011, 3'b111, 1'b0, -32'sd3, 32'd2, 32'h20, 32'h100, 4'd8,
             32'd0, 1'b1, 32'h120);
    dispatch(7'b1100011, 3'b000, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd9,
             32'd0, 1'b0, 32'h104);
    dispatch(7'b1100011, 3'b001, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd10,
             32'd0, 1'b1, 32'h120);
    dispatch(7'b1100011, 3'b101, 1'b0, -32'sd3, 32'd2, 32'h20, 32'h100, 4'd11,
             32'd0, 1'b0, 32'h104);
    dispatch(7'b1100011, 3'b110, 1'b0, -32'sd3, 32'd2, 32'h20, 32'h100, 4'd12,
             32'd0, 1'b0, 32'h104);
    drain();
  endtask

  task automatic test_jump();
    dispatch(7'b1100111, 3'b000, 1'b0, 32'h1003, 32'd0, 32'd2, 32'h40, 4'd1,
             32'h44, 1'b1, 32'h1004);
    dispatch(7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 4'd2,
             32'h10, 1'b0, 32'hFFFF_FFF4);
    dispatch(7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h1000, 4'd3,
             32'h1004, 1'b1, 32'h0FF0);
    dispatch(7'b0110111, 3'b000, 1'b0, 32'd5, 32'd6, 32'hABCD_E000, 32'h2000, 4'd4,
             32'hABCD_E000, 1'b0, 32'h2004);
    drain();
  endtask

  task automatic test_unknown();
    dispatch(7'b0000011, 3'b010, 1'b0, 32'd9, 32'd9, 32'd4, 32'h300, 4'd13,
             32'd0, 1'b0, 32'h304);
    dispatch(7'b1100011, 3'b010, 1'b0, 32'd1, 32'd1, 32'h40, 32'h304, 4'd14,
             32'd0, 1'b0, 32'h308);
    dispatch(7'b1100111, 3'b001, 1'b0, 32'h500, 32'd0, 32'd8, 32'h308, 4'd15,
             32'd0, 1'b0, 32'h30C);
    drain();
  endtask

  task automatic test_stall();
    dispatch(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h200, 4'd6,
             32'h1234_5000, 1'b0, 32'h204);
    alu_en = 1'b0;
    repeat (LAT - 1) cycle();
    // result is now high; freeze and offer a dispatch that must be ignored
    rdy = 1'b0;
    put(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'h600, 4'd9);
    for (int i = 0; i < 3; i++) begin
      cycle();
      @(negedge clk);
      n_tests++;
      if (result !== 1'b1 || result_rob_pos !== 4'd6 || result_val !== 32'h1234_5000 ||
          result_jump !== 1'b0 || result_pc !== 32'h204) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got result=%b rob=%0d val=%h jump=%b pc=%h, required 1 6 12345000 0 00000204",
                 i, result, result_rob_pos, result_val, result_jump, result_pc);
      end
    end
    rdy    = 1'b1;
    alu_en = 1'b0;
    cycle();
    @(negedge clk);
    n_tests++;
    if (result !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got result=%b, required 0", result);
    end
    drain();
  endtask

  task automatic check_flushed(input string name);
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      n_tests++;
      if (result !== 1'b0 || result_val !== 32'd0 || result_pc !== 32'd0 ||
          result_jump !== 1'b0 || result_rob_pos !== 4'd0) begin
        n_fail++;
        $display("FAIL %s[%0d]: got result=%b rob=%0d val=%h jump=%b pc=%h, required all zero",
                 name, k, result, result_rob_pos, result_val, result_jump, result_pc);
      end
      cycle();
    end
  endtask

  task automatic test_rollback();
    // dispatch in the same cycle as rollback is dropped
    put(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h400, 4'd7);
    rollback = 1'b1;
    cycle();
    rollback = 1'b0;
    alu_en   = 1'b0;
    check_flushed("rollback_same_cycle");

    // rollback while work is in flight
    put(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h500, 4'd8);
    if (LAT == 1) expect_res(4'd8, 32'd3, 1'b0, 32'h504);
    cycle();
    put(7'b0110011, 3'b100, 1'b0, 32'd3, 32'd5, 32'd0, 32'h504, 4'd9);
    rollback = 1'b1;
    cycle();
    rollback = 1'b0;
    alu_en   = 1'b0;
    check_flushed("rollback_in_flight");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [2:0]  f3;
    logic        f7;
    int          sel;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 4);
      f7  = 1'b0;
      case (sel)
        0:       begin f3 = 3'b000; y = a + b; end
        1:       begin f3 = 3'b000; f7 = 1'b1; y = a - b; end
        2:       begin f3 = 3'b100; y = a ^ b; end
        3:       begin f3 = 3'b110; y = a | b; end
        default: begin f3 = 3'b111; y = a & b; end
      endcase
      dispatch(7'b0110011, f3, f7, a, b, 32'd0, 32'h8000 + 32'(i * 4), 4'(i),
               y, 1'b0, 32'h8004 + 32'(i * 4));
    end
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    rdy         = 1'b1;
    rollback    = 1'b0;
    alu_en      = 1'b0;
    alu_opcode  = 7'd0;
    alu_funct3  = 3'd0;
    alu_funct7  = 1'b0;
    alu_val1    = 32'd0;
    alu_val2    = 32'd0;
    alu_imm     = 32'd0;
    alu_pc      = 32'd0;
    alu_rob_pos = 4'd0;

    test_reset();
    test_latency_sub();
    test_shift_slt();
    test_branch();
    test_jump();
    test_unknown();
    test_stall();
    test_rollback();
    test_back_to_back();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results still outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
